// File: rtl/mm_pkg.sv
// Shared definitions for the matrix multiplier datapath: default operand
// geometry and the drain state encoding used by result_regfile.
package mm_pkg;

    // Default entry width and entry count shared with the multiplier.
    localparam int MM_DATA_W = 8;
    localparam int MM_DEPTH  = 8;

    // Drain sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/rf_acc_unit.sv
// Accumulate adder for result_regfile: adds an addend to a stored entry,
// reports the carry out of the top bit, and either wraps or saturates.
// Build option: define RESULT_REGFILE_SAT_EN to clamp at all-ones on carry.
module rf_acc_unit
    import mm_pkg::*;
#(
    parameter int DATA_W = MM_DATA_W
) (
    input  logic [DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0] addend,
    output logic [DATA_W-1:0] sum,
    output logic              carry
);

    logic [DATA_W:0] wide_sum;

    // One-bit-wider add so the carry is visible; select wrap or clamp.
    always_comb begin
        wide_sum = {1'b0, acc_in} + {1'b0, addend};
        carry    = wide_sum[DATA_W];
`ifdef RESULT_REGFILE_SAT_EN
        sum      = carry ? {DATA_W{1'b1}} : wide_sum[DATA_W-1:0];
`else
        sum      = wide_sum[DATA_W-1:0];
`endif
    end

endmodule

// File: rtl/result_regfile.sv
// Result register file for the matrix multiplier. DEPTH entries written as
// overwrite or accumulate-in-place, exposed flat with per-entry valid bits,
// and streamed out in address order through a valid/ready drain port.
// Build option: RESULT_REGFILE_SAT_EN (saturating accumulate, see rf_acc_unit).
module result_regfile
    import mm_pkg::*;
#(
    parameter  int DATA_W = MM_DATA_W,
    parameter  int DEPTH  = MM_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic                    wr_acc,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [DEPTH*DATA_W-1:0] contents,
    output logic [DEPTH-1:0]        valid_mask,
    output logic                    all_valid,
    output logic                    overflow,
    output logic                    wr_drop,
    input  logic                    drain_start,
    output logic                    drain_busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_W-1:0]       out_addr,
    output logic [DATA_W-1:0]       out_data,
    output logic                    drain_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] entries_q [DEPTH];
    logic [DATA_W-1:0] entries_d [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic              overflow_q;
    logic              overflow_d;
    logic              wr_drop_q;
    logic              wr_drop_d;
    drain_state_e      state_q;
    drain_state_e      state_d;
    logic [ADDR_W-1:0] out_addr_q;
    logic [ADDR_W-1:0] out_addr_d;

    logic              addr_ok;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_idx;
    logic [DATA_W-1:0] acc_sum;
    logic              acc_carry;

    // Write qualification; out-of-range addresses are steered to entry 0 so
    // the accumulate read never indexes past the array (the write is dropped).
    always_comb begin
        addr_ok = (int'(wr_addr) < DEPTH);
        wr_ok   = wr_en && addr_ok && (state_q == ST_IDLE);
        wr_idx  = addr_ok ? wr_addr : '0;
    end

    rf_acc_unit #(
        .DATA_W (DATA_W)
    ) u_acc (
        .acc_in (entries_q[wr_idx]),
        .addend (wr_data),
        .sum    (acc_sum),
        .carry  (acc_carry)
    );

    // Next-state for entries, flags and the drain sequencer. Clear wins over
    // any write or drain activity in the same cycle.
    always_comb begin
        entries_d  = entries_q;
        valid_d    = valid_q;
        overflow_d = overflow_q;
        wr_drop_d  = wr_drop_q;
        state_d    = state_q;
        out_addr_d = out_addr_q;

        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            valid_d    = '0;
            overflow_d = 1'b0;
            wr_drop_d  = 1'b0;
            state_d    = ST_IDLE;
            out_addr_d = '0;
        end else begin
            // Writes: blocked while draining so drain data cannot change.
            if (wr_en && !wr_ok) begin
                wr_drop_d = 1'b1;
            end
            if (wr_ok) begin
                entries_d[wr_idx] = wr_acc ? acc_sum : wr_data;
                valid_d[wr_idx]   = 1'b1;
                if (wr_acc && acc_carry) begin
                    overflow_d = 1'b1;
                end
            end

            // Drain sequencer: one entry per accepted handshake, then a
            // single DONE cycle that produces the drain_done pulse.
            case (state_q)
                ST_IDLE: begin
                    if (drain_start) begin
                        state_d    = ST_DRAIN;
                        out_addr_d = '0;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (out_addr_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            out_addr_d = out_addr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_d    = ST_IDLE;
                    out_addr_d = '0;
                end
                default: begin
                    state_d    = ST_IDLE;
                    out_addr_d = '0;
                end
            endcase
        end
    end

    // State registers with synchronous reset of everything, data included.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            valid_q    <= '0;
            overflow_q <= 1'b0;
            wr_drop_q  <= 1'b0;
            state_q    <= ST_IDLE;
            out_addr_q <= '0;
        end else begin
            entries_q  <= entries_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            wr_drop_q  <= wr_drop_d;
            state_q    <= state_d;
            out_addr_q <= out_addr_d;
        end
    end

    // Flatten the entry array onto the contents bus.
    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign contents[g*DATA_W +: DATA_W] = entries_q[g];
    end

    assign valid_mask = valid_q;
    assign all_valid  = &valid_q;
    assign overflow   = overflow_q;
    assign wr_drop    = wr_drop_q;
    assign drain_busy = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DRAIN);
    assign out_addr   = out_addr_q;
    assign out_data   = entries_q[out_addr_q];
    assign drain_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_result_regfile.sv
// Directed plus randomized bench for result_regfile against a simple
// array-based model of the entries, valid bits and sticky flags.
module tb_result_regfile;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        wr_en;
    logic        wr_acc;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [63:0] contents;
    logic [7:0]  valid_mask;
    logic        all_valid;
    logic        overflow;
    logic        wr_drop;
    logic        drain_start;
    logic        drain_busy;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_addr;
    logic [7:0]  out_data;
    logic        drain_done;

    // Second instance with a non power-of-two depth for bad-address writes.
    logic        wr_en5;
    logic [2:0]  wr_addr5;
    logic [7:0]  wr_data5;
    logic [39:0] contents5;
    logic [4:0]  valid5;
    logic        all_valid5;
    logic        ovf5;
    logic        drop5;
    logic        busy5;
    logic        ov5;
    logic [2:0]  oaddr5;
    logic [7:0]  odata5;
    logic        done5;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    int m_ent [8];
    bit [7:0] m_vld;
    bit m_ovf;
    bit m_drop;

    result_regfile dut (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en), .wr_acc(wr_acc), .wr_addr(wr_addr), .wr_data(wr_data),
        .contents(contents), .valid_mask(valid_mask), .all_valid(all_valid),
        .overflow(overflow), .wr_drop(wr_drop),
        .drain_start(drain_start), .drain_busy(drain_busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .drain_done(drain_done)
    );

    result_regfile #(.DATA_W(8), .DEPTH(5)) dut5 (
        .clk(clk), .reset(reset), .clear(clear),
        .wr_en(wr_en5), .wr_acc(1'b0), .wr_addr(wr_addr5), .wr_data(wr_data5),
        .contents(contents5), .valid_mask(valid5), .all_valid(all_valid5),
        .overflow(ovf5), .wr_drop(drop5),
        .drain_start(1'b0), .drain_busy(busy5),
        .out_valid(ov5), .out_ready(1'b0),
        .out_addr(oaddr5), .out_data(odata5), .drain_done(done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_ent[i] = 0;
        m_vld  = '0;
        m_ovf  = 1'b0;
        m_drop = 1'b0;
    endtask

    task automatic model_write(input int a, input bit acc, input int d, input bit busy);
        int s;
        if (busy || a >= 8) begin
            m_drop = 1'b1;
        end else begin
            if (acc) begin
                s = m_ent[a] + d;
                if (s > 255) begin
                    m_ovf = 1'b1;
`ifdef RESULT_REGFILE_SAT_EN
                    s = 255;
`else
                    s = s - 256;
`endif
                end
                m_ent[a] = s;
            end else begin
                m_ent[a] = d;
            end
            m_vld[a] = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        logic [63:0] e;
        for (int i = 0; i < 8; i++) e[i*8 +: 8] = m_ent[i][7:0];
        chk({tag, "_contents"}, contents, e);
        chk({tag, "_valid_mask"}, valid_mask, m_vld);
        chk({tag, "_all_valid"}, all_valid, &m_vld);
        chk({tag, "_overflow"}, overflow, m_ovf);
        chk({tag, "_wr_drop"}, wr_drop, m_drop);
    endtask

    task automatic do_write(input int a, input bit acc, input int d);
        wr_en   = 1'b1;
        wr_acc  = acc;
        wr_addr = a[2:0];
        wr_data = d[7:0];
        cyc();
        wr_en = 1'b0;
        model_write(a, acc, d, 1'b0);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random.
    // wr_at_start issues a write in the drain_start cycle; clear_at >= 0
    // asserts clear on that beat index and abandons the drain.
    task automatic run_drain(input string tag, input int mode, input bit wr_at_start,
                             input bit wr_during, input int clear_at);
        int snap [8];
        int idx;
        int cnt;
        bit rdy;
        int wa;
        int wd;
        bit wacc;
        drain_start = 1'b1;
        if (wr_at_start) begin
            wa = int'($urandom_range(0, 7));
            wd = int'($urandom_range(0, 255));
            wr_en = 1'b1; wr_acc = 1'b0; wr_addr = wa[2:0]; wr_data = wd[7:0];
        end
        cyc();
        drain_start = 1'b0;
        wr_en = 1'b0;
        if (wr_at_start) model_write(wa, 1'b0, wd, 1'b0);
        snap = m_ent;
        idx = 0;
        cnt = 0;
        while (idx < 8 && cnt < 200) begin
            chk({tag, "_out_valid"}, out_valid, 1'b1);
            chk({tag, "_out_addr"}, out_addr, idx);
            chk({tag, "_out_data"}, out_data, snap[idx][7:0]);
            chk({tag, "_done_early"}, drain_done, 1'b0);
            if (clear_at >= 0 && idx == clear_at) begin
                clear = 1'b1;
                out_ready = 1'b1;
                cyc();
                clear = 1'b0;
                out_ready = 1'b0;
                model_clear();
                chk({tag, "_clr_out_valid"}, out_valid, 1'b0);
                chk({tag, "_clr_busy"}, drain_busy, 1'b0);
                chk({tag, "_clr_done"}, drain_done, 1'b0);
                check_state({tag, "_clr"});
                cyc();
                chk({tag, "_clr_done_next"}, drain_done, 1'b0);
                chk({tag, "_clr_out_valid_next"}, out_valid, 1'b0);
                return;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cnt % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (wr_during && ($urandom_range(0, 2) == 0)) begin
                wa   = int'($urandom_range(0, 7));
                wd   = int'($urandom_range(0, 255));
                wacc = 1'($urandom_range(0, 1));
                wr_en = 1'b1; wr_acc = wacc; wr_addr = wa[2:0]; wr_data = wd[7:0];
                model_write(wa, wacc, wd, 1'b1);
            end
            cyc();
            out_ready = 1'b0;
            wr_en = 1'b0;
            if (rdy) idx++;
            cnt++;
        end
        if (cnt >= 200) begin
            chk({tag, "_timeout"}, 64'(cnt), 64'd0);
        end
        if (mode == 0) chk({tag, "_beat_cycles"}, 64'(cnt), 64'd8);
        chk({tag, "_drain_done"}, drain_done, 1'b1);
        chk({tag, "_done_out_valid"}, out_valid, 1'b0);
        check_state({tag, "_after"});
        cyc();
        chk({tag, "_done_pulse_end"}, drain_done, 1'b0);
        chk({tag, "_idle"}, drain_busy, 1'b0);
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0;
        wr_en = 1'b0; wr_acc = 1'b0; wr_addr = '0; wr_data = '0;
        drain_start = 1'b0; out_ready = 1'b0;
        wr_en5 = 1'b0; wr_addr5 = '0; wr_data5 = '0;
        model_clear();
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        check_state("reset");
        chk("reset_busy", drain_busy, 1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_addr", out_addr, 3'd0);
        chk("reset_drain_done", drain_done, 1'b0);
        chk("reset5_contents", contents5, 40'd0);
        chk("reset5_flags", {valid5, all_valid5, ovf5, drop5, busy5, ov5, done5}, 11'd0);
        chk("reset5_out", {oaddr5, odata5}, 11'd0);

        // Single overwrite
        do_write(3, 1'b0, 8'h12);
        chk("wr3_entry", contents[31:24], 8'h12);
        chk("wr3_mask", valid_mask, 8'h08);
        check_state("wr3");

        // Overwrite then accumulate with carry
        do_write(5, 1'b0, 8'hF0);
        do_write(5, 1'b1, 8'h20);
`ifdef RESULT_REGFILE_SAT_EN
        chk("acc5_entry", contents[47:40], 8'hFF);
`else
        chk("acc5_entry", contents[47:40], 8'h10);
`endif
        chk("acc5_overflow", overflow, 1'b1);
        check_state("acc5");

        // Fill 1..8 and drain at full rate
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        model_clear();
        check_state("clear");
        for (int i = 0; i < 8; i++) do_write(i, 1'b0, i + 1);
        chk("fill_all_valid", all_valid, 1'b1);
        check_state("fill");
        run_drain("drain_full", 0, 1'b0, 1'b0, -1);

        // Stalled drain with ready pattern 1,0,0,...
        run_drain("drain_stall", 1, 1'b0, 1'b0, -1);

        // Writes attempted during drain are dropped
        run_drain("drain_wr", 2, 1'b0, 1'b1, -1);

        // Clear the drop flag, then write and drain_start in the same cycle
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        model_clear();
        for (int i = 0; i < 8; i++) do_write(i, 1'b0, int'($urandom_range(0, 255)));
        run_drain("drain_wrstart", 0, 1'b1, 1'b0, -1);

        // Clear on the third beat
        run_drain("drain_clear", 0, 1'b0, 1'b0, 2);

        // Randomized writes: overwrite and accumulate, any address
        for (int k = 0; k < 60; k++) begin
            int a;
            int d;
            bit acc;
            bit en;
            a   = int'($urandom_range(0, 7));
            d   = int'($urandom_range(0, 255));
            acc = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 9) < 7);
            wr_en = en; wr_acc = acc; wr_addr = a[2:0]; wr_data = d[7:0];
            cyc();
            wr_en = 1'b0;
            if (en) model_write(a, acc, d, 1'b0);
            check_state("rand");
        end
        run_drain("drain_rand", 2, 1'b0, 1'b1, -1);

        // Bad address on the DEPTH=5 instance
        wr_en5 = 1'b1; wr_addr5 = 3'd6; wr_data5 = 8'hAA;
        cyc();
        wr_en5 = 1'b0;
        chk("bad_addr_drop", drop5, 1'b1);
        chk("bad_addr_contents", contents5, 40'd0);
        chk("bad_addr_mask", valid5, 5'd0);
        wr_en5 = 1'b1; wr_addr5 = 3'd4; wr_data5 = 8'h33;
        cyc();
        wr_en5 = 1'b0;
        chk("d5_wr4_contents", contents5, {8'h33, 32'd0});
        chk("d5_wr4_mask", valid5, 5'h10);
        chk("d5_all_valid", all_valid5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
